// File: rtl/mest_pro_pkg.sv
// Shared types and defaults for the MESTPro instruction-sequencing controller.
package mest_pro_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        HALT    = 3'd4,
        ERROR   = 3'd5
    } mest_pro_seq_state_e;

    localparam int unsigned CNT_W_DEF          = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

endpackage

// File: rtl/mest_pro_wdog.sv
// Watchdog timer for the sequencer wait states. o_expired flags the
// TIMEOUT_CYCLES-th cycle spent waiting since the last clear.
module mest_pro_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;

    // Timer clears on state entry and advances once per waiting cycle.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            timer <= '0;
        end else if (i_clear) begin
            timer <= '0;
        end else if (i_count && !o_expired) begin
            timer <= timer + 1'b1;
        end
    end

    // Timer holds (cycle-in-state - 1), so the limit is one below TIMEOUT_CYCLES.
    always_comb begin
        o_expired = (timer == TW'(TIMEOUT_CYCLES - 1));
    end

endmodule

// File: rtl/mest_pro_seq_ctrlr.sv
// MESTPro instruction-sequencing controller: FETCH -> DECODE -> EXECUTE with
// handshake waits, pause/single-step, saturating retire counter.
// Optional watchdog/ERROR state built when MEST_PRO_SEQ_TIMEOUT_EN is defined.
module mest_pro_seq_ctrlr
    import mest_pro_pkg::*;
#(
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_step_mode,
    input  logic             i_resume,
    input  logic             i_fetch_valid,
    input  logic             i_exec_done,
    input  logic             i_end_of_code,
    input  logic             i_clear_err,
    output logic [2:0]       o_state,
    output logic             o_idle,
    output logic             o_fetch,
    output logic             o_decode,
    output logic             o_execute,
    output logic             o_halted,
    output logic             o_error,
    output logic             o_all_done,
    output logic [CNT_W-1:0] o_instr_count
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    mest_pro_seq_state_e state;
    mest_pro_seq_state_e next;
    logic                expired;
    logic                retire;

`ifdef MEST_PRO_SEQ_TIMEOUT_EN
    mest_pro_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_clear   (next != state),
        .i_count   (state == FETCH || state == EXECUTE),
        .o_expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Next-state logic; handshakes take priority over a watchdog expiry.
    always_comb begin
        next   = state;
        retire = 1'b0;
        case (state)
            IDLE:    if (i_start) next = FETCH;
            FETCH: begin
                if (i_fetch_valid) next = DECODE;
                else if (expired)  next = ERROR;
            end
            DECODE:  next = EXECUTE;
            EXECUTE: begin
                if (i_exec_done) begin
                    retire = 1'b1;
                    if (i_end_of_code)              next = IDLE;
                    else if (i_stop || i_step_mode) next = HALT;
                    else                            next = FETCH;
                end else if (expired) begin
                    next = ERROR;
                end
            end
            HALT:    if (i_resume) next = FETCH;
            ERROR:   if (i_clear_err) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Retired-instruction counter: cleared on start, saturates at all-ones.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            o_instr_count <= '0;
        end else if (state == IDLE && i_start) begin
            o_instr_count <= '0;
        end else if (retire && o_instr_count != '1) begin
            o_instr_count <= o_instr_count + 1'b1;
        end
    end

    // State decodes; o_all_done is the only output with input terms.
    always_comb begin
        o_state    = state;
        o_idle     = (state == IDLE);
        o_fetch    = (state == FETCH);
        o_decode   = (state == DECODE);
        o_execute  = (state == EXECUTE);
        o_halted   = (state == HALT);
`ifdef MEST_PRO_SEQ_TIMEOUT_EN
        o_error    = (state == ERROR);
`else
        o_error    = 1'b0;
`endif
        o_all_done = o_execute & i_exec_done & i_end_of_code;
    end

endmodule

// File: tb/tb_mest_pro_seq_ctrlr.sv
// Directed bench for mest_pro_seq_ctrlr (CNT_W=4, TIMEOUT_CYCLES=8).
// Watchdog checks build when MEST_PRO_SEQ_TIMEOUT_EN is defined.
module tb_mest_pro_seq_ctrlr;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, step_mode, resume;
    logic       fetch_valid, exec_done, end_of_code, clear_err;
    logic [2:0] state;
    logic       idle, fetch, decode, execute, halted, error, all_done;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    mest_pro_seq_ctrlr #(
        .CNT_W          (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_stop        (stop),
        .i_step_mode   (step_mode),
        .i_resume      (resume),
        .i_fetch_valid (fetch_valid),
        .i_exec_done   (exec_done),
        .i_end_of_code (end_of_code),
        .i_clear_err   (clear_err),
        .o_state       (state),
        .o_idle        (idle),
        .o_fetch       (fetch),
        .o_decode      (decode),
        .o_execute     (execute),
        .o_halted      (halted),
        .o_error       (error),
        .o_all_done    (all_done),
        .o_instr_count (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start from IDLE and sample the first FETCH cycle.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs one instruction from FETCH: valid after fd wait cycles, done after ed.
    task automatic run_instr(input int fd, input int ed, input logic eoc,
                             output int fcyc, output int ecyc);
        fcyc = 0;
        ecyc = 0;
        while (fetch && fcyc < 100) begin
            fetch_valid = (fcyc == fd);
            fcyc++;
            tick();
        end
        fetch_valid = 1'b0;
        tick();
        while (execute && ecyc < 100) begin
            exec_done   = (ecyc == ed);
            end_of_code = eoc && (ecyc == ed);
            ecyc++;
            tick();
        end
        exec_done   = 1'b0;
        end_of_code = 1'b0;
    endtask

    initial begin
        logic [2:0] seq [9];
        int         fc, ec, pulses, active;
        logic       err_seen;

        seq = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
        rst = 1'b1;
        {start, stop, step_mode, resume, fetch_valid, exec_done, end_of_code, clear_err} = '0;
        tick();
        tick();
        check("rst_state", 32'(state), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_decodes", 32'({fetch, decode, execute, halted, error}), 0);
        check("rst_all_done", 32'(all_done), 0);
        check("rst_count", 32'(count), 0);
        rst = 1'b0;
        tick();

        // Basic 3-instruction run with zero wait states.
        do_start();
        fetch_valid = 1'b1;
        exec_done   = 1'b1;
        pulses = 0;
        active = 0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("basic_seq%0d", i), 32'(state), 32'(seq[i]));
            end_of_code = (i == 8);
            start       = (i == 8);
            #1;
            if (all_done) pulses++;
            if (!idle) active++;
            tick();
        end
        {fetch_valid, exec_done, end_of_code, start} = '0;
        check("basic_active", 32'(active), 9);
        check("basic_done_pulses", 32'(pulses), 1);
        check("basic_start_ignored", 32'(state), 0);
        check("basic_count", 32'(count), 3);

        // Wait states on both handshakes.
        do_start();
        check("wait_count_cleared", 32'(count), 0);
        run_instr(4, 7, 1'b1, fc, ec);
        check("wait_fetch_cycles", 32'(fc), 5);
        check("wait_exec_cycles", 32'(ec), 8);
        check("wait_count", 32'(count), 1);
        check("wait_idle", 32'(idle), 1);

        // Single-step with HALT hold, ignored start/stop, held resume.
        step_mode = 1'b1;
        do_start();
        run_instr(0, 0, 1'b0, fc, ec);
        check("step1_halt", 32'(state), 4);
        check("step1_count", 32'(count), 1);
        start = 1'b1;
        stop  = 1'b1;
        repeat (6) tick();
        start = 1'b0;
        stop  = 1'b0;
        check("step_hold_halt", 32'(halted), 1);
        resume = 1'b1;
        tick();
        check("step_resume_fetch", 32'(fetch), 1);
        stop = 1'b1;
        run_instr(2, 0, 1'b0, fc, ec);
        check("step2_fetch_cycles", 32'(fc), 3);
        check("step2_halt", 32'(state), 4);
        check("step2_count", 32'(count), 2);
        resume    = 1'b0;
        step_mode = 1'b0;
        tick();
        check("step_no_resume", 32'(halted), 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        run_instr(0, 0, 1'b1, fc, ec);
        check("eoc_over_stop", 32'(state), 0);
        check("step3_count", 32'(count), 3);
        stop = 1'b0;

        // Saturation at 15 over 20 instructions.
        do_start();
        for (int i = 0; i < 20; i++) begin
            run_instr(0, 0, (i == 19), fc, ec);
            if (i == 14) check("sat_reach15", 32'(count), 15);
            if (i == 15) check("sat_hold15", 32'(count), 15);
        end
        check("sat_final", 32'(count), 15);
        check("sat_idle", 32'(idle), 1);
        do_start();
        check("sat_restart_clear", 32'(count), 0);
        run_instr(0, 0, 1'b1, fc, ec);

`ifdef MEST_PRO_SEQ_TIMEOUT_EN
        // EXECUTE timeout; count holds in ERROR.
        do_start();
        run_instr(0, 0, 1'b0, fc, ec);
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        tick();
        ec = 0;
        while (execute && ec < 50) begin
            ec++;
            tick();
        end
        check("to_exec_cycles", 32'(ec), 8);
        check("to_exec_error", 32'(state), 5);
        check("to_error_flag", 32'(error), 1);
        check("to_count_hold", 32'(count), 1);
        repeat (3) tick();
        check("to_error_hold", 32'(error), 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("to_clear_idle", 32'(idle), 1);

        // FETCH timeout.
        do_start();
        fc = 0;
        while (fetch && fc < 50) begin
            fc++;
            tick();
        end
        check("to_fetch_cycles", 32'(fc), 8);
        check("to_fetch_error", 32'(state), 5);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;

        // Handshakes in the 8th cycle beat the timeout.
        do_start();
        run_instr(7, 7, 1'b1, fc, ec);
        check("to_edge_fetch", 32'(fc), 8);
        check("to_edge_exec", 32'(ec), 8);
        check("to_edge_idle", 32'(state), 0);
`else
        // No watchdog: waiting indefinitely never raises an error.
        do_start();
        err_seen = 1'b0;
        repeat (1000) begin
            tick();
            err_seen |= error;
        end
        check("nowd_no_error", 32'(err_seen), 0);
        check("nowd_still_fetch", 32'(fetch), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        // Asynchronous reset mid-EXECUTE discards the partial instruction.
        do_start();
        run_instr(0, 0, 1'b0, fc, ec);
        check("mid_pre_count", 32'(count), 1);
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        tick();
        check("mid_in_execute", 32'(execute), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_async_idle", 32'(idle), 1);
        check("mid_async_count", 32'(count), 0);
        #1 rst = 1'b0;
        tick();
        check("mid_after_idle", 32'(state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mest_pro_seq_ctrlr.md
# mest_pro_seq_ctrlr

Parametrised instruction-sequencing controller for the MESTPro core. It steps FETCH→DECODE→EXECUTE and waits on memory and execute-unit handshakes instead of fixed single-cycle phases. It adds pause and single-step control, a saturating retired-instruction counter and an optional watchdog error state. It sits between the start/debug control inputs and the fetch, decode and execute datapath enables.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- TIMEOUT_CYCLES, 256, maximum cycles spent waiting in FETCH or EXECUTE before error; legal range 2..65535.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  begin a program run; sampled in IDLE only.
- i_stop  in  1  pause request; sampled at the instruction boundary only.
- i_step_mode  in  1  halt after every retired instruction.
- i_resume  in  1  leave HALT; sampled in HALT only.
- i_fetch_valid  in  1  instruction word available; completes FETCH.
- i_exec_done  in  1  execute unit finished; completes EXECUTE.
- i_end_of_code  in  1  current instruction is the last one.
- i_clear_err  in  1  leave ERROR; sampled in ERROR only.
- o_state  out  3  current state encoding.
- o_idle / o_fetch / o_decode / o_execute / o_halted / o_error  out  1 each  one-hot state decodes.
- o_all_done  out  1  program-complete indication.
- o_instr_count  out  CNT_W  retired instructions since the last start.

## Operation
- IDLE: on i_start, go to FETCH and clear o_instr_count to 0.
- FETCH: stay until i_fetch_valid, then go to DECODE.
- DECODE: always one cycle, then EXECUTE.
- EXECUTE: stay until i_exec_done. On done, the instruction retires and o_instr_count increments, saturating at 2^CNT_W−1.
- EXECUTE exit priority when done: i_end_of_code → IDLE; else i_stop or i_step_mode → HALT; else FETCH.
- HALT: on i_resume, go to FETCH. i_start and i_stop are ignored in HALT.
- ERROR: only reachable with the watchdog compiled in (see Configuration). On i_clear_err, go to IDLE. o_instr_count holds its value in ERROR.
- Undefined encodings (6, 7) go to IDLE on the next cycle.
- o_all_done is combinational: o_execute & i_exec_done & i_end_of_code. It pulses in the final EXECUTE cycle only.
- Outputs are decoded combinationally from the state register, with no glitch-prone input terms except o_all_done.

## Timing
- Reset values: state IDLE (0), o_idle=1, every other decode 0, o_all_done=0, o_instr_count=0, watchdog timer 0.
- A reset assertion mid-instruction forces IDLE asynchronously; the partial instruction is not counted.
- i_start high at edge N gives o_fetch=1 after edge N.
- Minimum instruction period is 3 cycles: FETCH with valid in its first cycle, DECODE, then EXECUTE with done in its first cycle.
- o_instr_count updates on the edge that leaves EXECUTE. It is visible in the following FETCH, HALT or IDLE cycle.
- i_start in the same cycle as o_all_done is ignored; the controller is not yet in IDLE.
- i_stop and i_step_mode are both high at a done: result is HALT, with one increment.
- Level-held i_resume while already in FETCH has no effect.

## Configuration
- MEST_PRO_SEQ_TIMEOUT_EN defined: a watchdog timer is active in FETCH and EXECUTE.
  - The timer clears on entry to either state and increments every waiting cycle.
  - If the handshake is still absent in the TIMEOUT_CYCLES-th cycle of the state, the next state is ERROR.
  - A handshake arriving in that same cycle wins over the timeout.
- MEST_PRO_SEQ_TIMEOUT_EN undefined: no timer logic is built, ERROR is unreachable, o_error is tied to 0, i_clear_err is ignored, and FETCH/EXECUTE wait indefinitely.

## Structure
- Shared package mest_pro_pkg holds:
  - typedef enum logic [2:0] mest_pro_seq_state_e: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, HALT=4, ERROR=5.
  - The default CNT_W and TIMEOUT_CYCLES constants.
- One sub-module, mest_pro_wdog, instantiated only under the macro.
  - Parameter TIMEOUT_CYCLES.
  - Inputs: clk, i_reset, i_clear, i_count.
  - Output: o_expired.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Basic run, 3 instructions:
  - Stimulus: start; valid and done on the first cycle of each wait state; end_of_code on the third instruction.
  - Required: 9 active cycles, o_all_done high for exactly 1 cycle, o_instr_count=3, then IDLE.
- Wait states:
  - Stimulus: fetch_valid delayed 4 cycles and exec_done delayed 7 cycles.
  - Required: o_fetch high 5 cycles and o_execute high 8 cycles; count increments only once.
- Step mode:
  - Stimulus: i_step_mode=1 for 2 instructions.
  - Required: HALT after each retire; i_resume gives FETCH on the next cycle; HALT is held indefinitely without resume.
- Saturation:
  - Stimulus: CNT_W=4, run 20 instructions.
  - Required: o_instr_count stops at 15. A new i_start clears it to 0.
- Timeout (macro on, TIMEOUT_CYCLES=8):
  - No exec_done: ERROR after exactly 8 EXECUTE cycles.
  - exec_done in the 8th cycle: no error.
  - i_clear_err: IDLE.
- Reset mid-EXECUTE:
  - Stimulus: assert i_reset between edges.
  - Required: o_idle=1 immediately (before the next edge) and count=0. Macro off: o_error stays 0 for 1000 waiting cycles.
